// File: rtl/video_pattern_gen.sv
// Raster test-pattern source: programmable blanking/sync timing driving a vs/de/data pixel stream.
// Counters run one clock ahead of the registered outputs.
module video_pattern_gen #(
    parameter logic [10:0] IMG_WIDTH  = 11'd640,
    parameter logic [10:0] IMG_HEIGHT = 11'd480,
    parameter logic [10:0] H_BLANK    = 11'd16,
    parameter logic [10:0] V_BLANK    = 11'd4,
    parameter logic [10:0] VS_WIDTH   = 11'd2,
    parameter int unsigned DATA_W     = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              single_frame,
    input  logic [1:0]        pattern_sel,
    output logic              busy,
    output logic              video_vs,
    output logic              video_de,
    output logic [DATA_W-1:0] video_data,
    output logic              frame_done,
    output logic [10:0]       x_pos,
    output logic [10:0]       y_pos
);

    localparam int unsigned LINE_LEN  = int'(IMG_WIDTH) + int'(H_BLANK);
    localparam int unsigned FRAME_LEN = int'(V_BLANK) + int'(IMG_HEIGHT);
    localparam logic [10:0] H_LAST    = 11'(LINE_LEN - 1);
    localparam logic [10:0] V_LAST    = 11'(FRAME_LEN - 1);

    typedef enum logic {StIdle, StRun} state_e;

    state_e              state_q, state_d;
    logic [10:0]         h_q, h_d, v_q, v_d;
    logic [1:0]          pat_q, pat_d;
    logic                single_q, single_d;
    logic [DATA_W-1:0]   inc_q, inc_d;

    logic                run, line_end, frame_end, cnt_vs, cnt_de;
    logic [10:0]         y_row;
    logic [DATA_W-1:0]   pix;

    always_comb begin
        run       = (state_q == StRun);
        line_end  = (h_q == H_LAST);
        frame_end = line_end && (v_q == V_LAST);
        cnt_vs    = (v_q < VS_WIDTH);
        cnt_de    = (v_q >= V_BLANK) && (h_q < IMG_WIDTH);
        y_row     = v_q - V_BLANK;
    end

    always_comb begin
        pix = '0;
        case (pat_q)
            2'd0:    pix = inc_q;
            2'd1:    pix = DATA_W'(h_q);
            2'd2:    pix = DATA_W'(y_row);
            default: pix = (h_q[3] ^ y_row[3]) ? '1 : '0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        h_d      = h_q;
        v_d      = v_q;
        pat_d    = pat_q;
        single_d = single_q;
        inc_d    = inc_q;
        unique case (state_q)
            StIdle: begin
                if (enable) begin
                    state_d  = StRun;
                    h_d      = '0;
                    v_d      = '0;
                    pat_d    = pattern_sel;
                    single_d = single_frame;
                    inc_d    = '0;
                end
            end
            StRun: begin
                if (cnt_de) begin
                    inc_d = inc_q + DATA_W'(1);
                end
                if (line_end) begin
                    h_d = '0;
                    v_d = v_q + 11'd1;
                end else begin
                    h_d = h_q + 11'd1;
                end
                // A frame always runs to completion; enable is only consulted here.
                if (frame_end) begin
                    h_d   = '0;
                    v_d   = '0;
                    inc_d = '0;
                    if (single_q || !enable) begin
                        state_d = StIdle;
                    end else begin
                        pat_d = pattern_sel;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            h_q      <= '0;
            v_q      <= '0;
            pat_q    <= '0;
            single_q <= 1'b0;
            inc_q    <= '0;
        end else begin
            state_q  <= state_d;
            h_q      <= h_d;
            v_q      <= v_d;
            pat_q    <= pat_d;
            single_q <= single_d;
            inc_q    <= inc_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy       <= 1'b0;
            video_vs   <= 1'b0;
            video_de   <= 1'b0;
            video_data <= '0;
            frame_done <= 1'b0;
            x_pos      <= '0;
            y_pos      <= '0;
        end else begin
            busy       <= run;
            video_vs   <= run && cnt_vs;
            video_de   <= run && cnt_de;
            video_data <= (run && cnt_de) ? pix : '0;
            frame_done <= run && frame_end;
            x_pos      <= run ? h_q : '0;
            y_pos      <= run ? y_row : '0;
        end
    end

endmodule

// File: tb/tb_video_pattern_gen.sv
// Scoreboard bench for video_pattern_gen: a 5x5 instance for timing/control and a 20x20
// instance for counter wrap and checkerboard.
module tb_video_pattern_gen;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en_a = 1'b0;
    logic en_b = 1'b0;
    logic single_frame = 1'b0;
    logic [1:0] pattern_sel = 2'd0;

    logic a_busy, a_vs, a_de, a_fd;
    logic [7:0] a_data;
    logic [10:0] a_x, a_y;
    logic b_busy, b_vs, b_de, b_fd;
    logic [7:0] b_data;
    logic [10:0] b_x, b_y;

    video_pattern_gen #(
        .IMG_WIDTH(11'd5), .IMG_HEIGHT(11'd5), .H_BLANK(11'd3), .V_BLANK(11'd2),
        .VS_WIDTH(11'd1), .DATA_W(8)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .enable(en_a), .single_frame(single_frame),
        .pattern_sel(pattern_sel), .busy(a_busy), .video_vs(a_vs), .video_de(a_de),
        .video_data(a_data), .frame_done(a_fd), .x_pos(a_x), .y_pos(a_y)
    );

    video_pattern_gen #(
        .IMG_WIDTH(11'd20), .IMG_HEIGHT(11'd20), .H_BLANK(11'd3), .V_BLANK(11'd2),
        .VS_WIDTH(11'd1), .DATA_W(8)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .enable(en_b), .single_frame(single_frame),
        .pattern_sel(pattern_sel), .busy(b_busy), .video_vs(b_vs), .video_de(b_de),
        .video_data(b_data), .frame_done(b_fd), .x_pos(b_x), .y_pos(b_y)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0]  d;
        logic [10:0] x;
        logic [10:0] y;
        int          off;
    } pix_t;

    pix_t qa[$];
    pix_t qb[$];

    int a_vs_n, a_de_n, a_fd_n, a_busy_n, a_first, a_fd_cyc, a_fd_prev;
    int b_de_n, b_fd_n, b_first;

    // Expected active pixels of one frame; off is the cycle distance from the first vs output.
    task automatic push_frame(input int inst, input int pat, input int fidx, input int w,
                              input int h);
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                pix_t p;
                logic [10:0] cv, rv;
                cv = 11'(c);
                rv = 11'(r);
                p.x = cv;
                p.y = rv;
                p.off = fidx * (w + 3) * (h + 2) + (r + 2) * (w + 3) + c;
                case (pat)
                    0:       p.d = 8'(r * w + c);
                    1:       p.d = 8'(c);
                    2:       p.d = 8'(r);
                    default: p.d = (cv[3] ^ rv[3]) ? 8'hff : 8'h00;
                endcase
                if (inst == 0) qa.push_back(p);
                else qb.push_back(p);
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (a_vs) begin
                a_vs_n++;
                if (a_first < 0) a_first = cyc;
            end
            if (a_busy) a_busy_n++;
            if (a_fd) begin
                a_fd_n++;
                a_fd_prev = a_fd_cyc;
                a_fd_cyc = cyc;
            end
            checks++;
            if (a_de) begin
                a_de_n++;
                if (qa.size() == 0) begin
                    errors++;
                    $display("FAIL a_unexpected_de: x=%0d y=%0d data=%0d, no pixel expected",
                             a_x, a_y, a_data);
                end else begin
                    pix_t e;
                    e = qa.pop_front();
                    if (a_data !== e.d || a_x !== e.x || a_y !== e.y || cyc - a_first != e.off)
                    begin
                        errors++;
                        $display("FAIL a_pixel: got d=%0d x=%0d y=%0d off=%0d, exp d=%0d x=%0d y=%0d off=%0d",
                                 a_data, a_x, a_y, cyc - a_first, e.d, e.x, e.y, e.off);
                    end
                end
            end else if (a_data !== 8'd0) begin
                errors++;
                $display("FAIL a_data_blank: got %0d, expected 0", a_data);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (b_vs && b_first < 0) b_first = cyc;
            if (b_fd) b_fd_n++;
            if (b_de) begin
                b_de_n++;
                checks++;
                if (qb.size() == 0) begin
                    errors++;
                    $display("FAIL b_unexpected_de: x=%0d y=%0d data=%0d, no pixel expected",
                             b_x, b_y, b_data);
                end else begin
                    pix_t e;
                    e = qb.pop_front();
                    if (b_data !== e.d || b_x !== e.x || b_y !== e.y || cyc - b_first != e.off)
                    begin
                        errors++;
                        $display("FAIL b_pixel: got d=%0d x=%0d y=%0d off=%0d, exp d=%0d x=%0d y=%0d off=%0d",
                                 b_data, b_x, b_y, cyc - b_first, e.d, e.x, e.y, e.off);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clr_stats();
        a_vs_n = 0; a_de_n = 0; a_fd_n = 0; a_busy_n = 0;
        a_first = -1; a_fd_cyc = 0; a_fd_prev = 0;
        b_de_n = 0; b_fd_n = 0; b_first = -1;
    endtask

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic test_reset();
        clr_stats();
        rst_n = 1'b0;
        repeat (3) tick();
        checks++;
        if ({a_busy, a_vs, a_de, a_data, a_fd, a_x, a_y} !== 34'd0) begin
            errors++;
            $display("FAIL reset_a: got %h, expected 0", {a_busy, a_vs, a_de, a_data, a_fd, a_x, a_y});
        end
        checks++;
        if ({b_busy, b_vs, b_de, b_data, b_fd, b_x, b_y} !== 34'd0) begin
            errors++;
            $display("FAIL reset_b: got %h, expected 0", {b_busy, b_vs, b_de, b_data, b_fd, b_x, b_y});
        end
        rst_n = 1'b1;
        repeat (3) tick();
        checks++;
        if ({a_busy, a_vs, a_de, a_fd} !== 4'd0) begin
            errors++;
            $display("FAIL idle_after_reset: got %b, expected 0000", {a_busy, a_vs, a_de, a_fd});
        end
    endtask

    task automatic test_single_frame();
        int t0;
        clr_stats();
        push_frame(0, 0, 0, 5, 5);
        single_frame = 1'b1;
        pattern_sel = 2'd0;
        en_a = 1'b1;
        t0 = cyc;
        tick();
        en_a = 1'b0;
        for (int i = 0; i < 100 && a_fd_n == 0; i++) tick();
        repeat (5) tick();
        chk("single_vs_rise", a_first, t0 + 2);
        chk("single_vs_len", a_vs_n, 8);
        chk("single_de_count", a_de_n, 25);
        chk("single_fd_count", a_fd_n, 1);
        chk("single_fd_pos", a_fd_cyc - a_first, 55);
        chk("single_busy_len", a_busy_n, 56);
        chk("single_busy_end", int'(a_busy), 0);
        chk("single_queue", qa.size(), 0);
    endtask

    task automatic test_back_to_back();
        clr_stats();
        for (int f = 0; f < 3; f++) push_frame(0, 1, f, 5, 5);
        single_frame = 1'b0;
        pattern_sel = 2'd1;
        en_a = 1'b1;
        for (int i = 0; i < 300 && a_fd_n < 2; i++) tick();
        en_a = 1'b0;
        for (int i = 0; i < 100 && a_fd_n < 3; i++) tick();
        repeat (5) tick();
        chk("b2b_fd_count", a_fd_n, 3);
        chk("b2b_fd_spacing", a_fd_cyc - a_fd_prev, 56);
        chk("b2b_de_count", a_de_n, 75);
        chk("b2b_vs_count", a_vs_n, 24);
        chk("b2b_busy_len", a_busy_n, 168);
        chk("b2b_queue", qa.size(), 0);
        pattern_sel = 2'd0;
    endtask

    task automatic test_wrap();
        clr_stats();
        push_frame(1, 0, 0, 20, 20);
        push_frame(1, 0, 1, 20, 20);
        push_frame(1, 3, 2, 20, 20);
        single_frame = 1'b0;
        pattern_sel = 2'd0;
        en_b = 1'b1;
        for (int i = 0; i < 600 && b_fd_n < 1; i++) tick();
        pattern_sel = 2'd3;
        for (int i = 0; i < 600 && b_fd_n < 2; i++) tick();
        en_b = 1'b0;
        for (int i = 0; i < 600 && b_fd_n < 3; i++) tick();
        repeat (5) tick();
        chk("wrap_fd_count", b_fd_n, 3);
        chk("wrap_de_count", b_de_n, 1200);
        chk("wrap_queue", qb.size(), 0);
        chk("wrap_busy_end", int'(b_busy), 0);
        pattern_sel = 2'd0;
    endtask

    task automatic test_enable_drop();
        clr_stats();
        push_frame(0, 0, 0, 5, 5);
        single_frame = 1'b0;
        pattern_sel = 2'd0;
        en_a = 1'b1;
        // Pixel (2,1) is the eighth active pixel.
        for (int i = 0; i < 100 && a_de_n < 8; i++) tick();
        en_a = 1'b0;
        for (int i = 0; i < 100 && a_fd_n < 1; i++) tick();
        repeat (20) tick();
        chk("drop_de_count", a_de_n, 25);
        chk("drop_fd_count", a_fd_n, 1);
        chk("drop_vs_count", a_vs_n, 8);
        chk("drop_busy_end", int'(a_busy), 0);
        chk("drop_queue", qa.size(), 0);
    endtask

    task automatic test_pattern_change();
        clr_stats();
        push_frame(0, 0, 0, 5, 5);
        push_frame(0, 2, 1, 5, 5);
        single_frame = 1'b0;
        pattern_sel = 2'd0;
        en_a = 1'b1;
        for (int i = 0; i < 100 && a_de_n < 10; i++) tick();
        pattern_sel = 2'd2;
        for (int i = 0; i < 100 && a_fd_n < 1; i++) tick();
        en_a = 1'b0;
        for (int i = 0; i < 100 && a_fd_n < 2; i++) tick();
        repeat (5) tick();
        chk("patchg_de_count", a_de_n, 50);
        chk("patchg_fd_count", a_fd_n, 2);
        chk("patchg_queue", qa.size(), 0);
        pattern_sel = 2'd0;
    endtask

    task automatic test_reset_mid_frame();
        int t0;
        clr_stats();
        push_frame(0, 0, 0, 5, 5);
        single_frame = 1'b0;
        pattern_sel = 2'd0;
        en_a = 1'b1;
        for (int i = 0; i < 100 && a_de_n < 8; i++) tick();
        chk("midrst_in_active", int'(a_de), 1);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({a_vs, a_de, a_data, a_busy, a_fd, a_x, a_y} !== 34'd0) begin
            errors++;
            $display("FAIL midrst_outputs: got %h, expected 0",
                     {a_vs, a_de, a_data, a_busy, a_fd, a_x, a_y});
        end
        qa.delete();
        clr_stats();
        single_frame = 1'b1;
        push_frame(0, 0, 0, 5, 5);
        tick();
        rst_n = 1'b1;
        t0 = cyc;
        tick();
        en_a = 1'b0;
        for (int i = 0; i < 100 && a_fd_n < 1; i++) tick();
        repeat (5) tick();
        chk("midrst_vs_rise", a_first, t0 + 2);
        chk("midrst_de_count", a_de_n, 25);
        chk("midrst_fd_count", a_fd_n, 1);
        chk("midrst_queue", qa.size(), 0);
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_wrap();
        test_enable_drop();
        test_pattern_change();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
